div_wb_stage: RTL and testbench

- Writeback stage directly downstream of the iterative divider.
- Captures each issued operand pair; consumes the divider's quotient, remainder, rd and alu_control.
- Applies RV64M result selection and fix-ups: divide-by-zero, signed overflow, W-variant sign extension.
- Buffers finished results and merges them onto the register-file write port, with the main pipeline having priority. Keeps a per-register busy scoreboard for hazard stalls.

---
 rtl/div_pkg.sv | 18 +
 rtl/div_wb_stage_fifo.sv | 47 ++++
 rtl/div_wb_stage.sv | 146 ++++++++++++++
 tb/tb_div_wb_stage.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared opcodes and constants for the divider writeback stage.
package div_pkg;

    localparam int XLEN_DEFAULT = 64;

    localparam logic [4:0] OP_DIV   = 5'd12;
    localparam logic [4:0] OP_DIVU  = 5'd13;
    localparam logic [4:0] OP_REM   = 5'd14;
    localparam logic [4:0] OP_REMU  = 5'd15;
    localparam logic [4:0] OP_DIVW  = 5'd16;
    localparam logic [4:0] OP_DIVUW = 5'd17;
    localparam logic [4:0] OP_REMW  = 5'd18;
    localparam logic [4:0] OP_REMUW = 5'd19;

    localparam logic [63:0] MIN_S64 = 64'h8000_0000_0000_0000;
    localparam logic [31:0] MIN_S32 = 32'h8000_0000;

endpackage

// File: rtl/div_wb_stage_fifo.sv
// Small synchronous FIFO with occupancy count; head is visible combinationally.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           push,
    input  logic [WIDTH-1:0]               push_data,
    input  logic                           pop,
    output logic [WIDTH-1:0]               pop_data,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop   = pop && (count != '0);
    assign do_push  = push && ((count != FULL) || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/div_wb_stage.sv
// Divider writeback: operand capture, RV64M fix-ups, result buffering,
// register-file port merge behind the main pipeline, and busy scoreboard.
module div_wb_stage
    import div_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int XLEN  = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            issue_valid,
    output logic            issue_ready,
    input  logic [XLEN-1:0] issue_a,
    input  logic [XLEN-1:0] issue_b,
    input  logic [4:0]      issue_rd,
    input  logic [4:0]      issue_alu_control,
    input  logic            div_out_valid,
    input  logic [XLEN-1:0] div_q,
    input  logic [XLEN-1:0] div_r,
    input  logic [4:0]      div_rd,
    input  logic [4:0]      div_alu_control,
    input  logic            pipe_wb_en,
    input  logic [4:0]      pipe_wb_rd,
    input  logic [XLEN-1:0] pipe_wb_data,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic [31:0]     div_busy,
    output logic            seq_err
);

    localparam int OW = 2 * XLEN + 10;
    localparam int RW = XLEN + 5;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    logic [CW-1:0]   opq_count;
    logic [CW-1:0]   resq_count;
    logic [OW-1:0]   opq_head;
    logic [RW-1:0]   resq_head;
    logic            accept;
    logic            opq_nonempty;
    logic            strobe_take;
    logic            wb_pop;
    logic [XLEN-1:0] head_a;
    logic [XLEN-1:0] head_b;
    logic [4:0]      head_rd;
    logic [4:0]      head_op;
    logic [4:0]      res_rd;
    logic [XLEN-1:0] res_data;
    logic [XLEN-1:0] result;
    logic [31:0]     busy_next;

    // Counting in-flight operands plus buffered results guarantees room for every strobe.
    assign issue_ready  = ({1'b0, opq_count} + {1'b0, resq_count}) < DEPTH_C;
    assign accept       = issue_valid && issue_ready;
    assign opq_nonempty = (opq_count != '0);
    assign strobe_take  = div_out_valid && opq_nonempty;
    assign wb_pop       = !pipe_wb_en && (resq_count != '0);

    assign head_a   = opq_head[OW-1 -: XLEN];
    assign head_b   = opq_head[XLEN+9 -: XLEN];
    assign head_rd  = opq_head[9:5];
    assign head_op  = opq_head[4:0];
    assign res_rd   = resq_head[RW-1 -: 5];
    assign res_data = resq_head[XLEN-1:0];

    sync_fifo #(.WIDTH(OW), .DEPTH(DEPTH)) u_opq (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (accept),
        .push_data ({issue_a, issue_b, issue_rd, issue_alu_control}),
        .pop       (strobe_take),
        .pop_data  (opq_head),
        .count     (opq_count)
    );

    always_comb begin
        logic            is_w;
        logic            is_rem;
        logic            is_signed;
        logic            known;
        logic            b_zero;
        logic            ovf;
        logic [XLEN-1:0] quot;
        logic [XLEN-1:0] rem;
        logic [XLEN-1:0] sel;
        is_w      = div_alu_control inside {OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW};
        is_rem    = div_alu_control inside {OP_REM, OP_REMU, OP_REMW, OP_REMUW};
        is_signed = div_alu_control inside {OP_DIV, OP_REM, OP_DIVW, OP_REMW};
        known     = div_alu_control inside {[OP_DIV:OP_REMUW]};
        b_zero    = is_w ? (head_b[31:0] == '0) : (head_b == '0);
        ovf       = is_signed && (is_w ? ((head_a[31:0] == MIN_S32) && (head_b[31:0] == '1))
                                       : ((head_a == MIN_S64) && (head_b == '1)));
        quot      = b_zero ? '1 : (ovf ? head_a : div_q);
        rem       = b_zero ? head_a : (ovf ? '0 : div_r);
        sel       = is_rem ? rem : quot;
        if (!known)    result = div_q;
        else if (is_w) result = {{(XLEN-32){sel[31]}}, sel[31:0]};
        else           result = sel;
    end

    sync_fifo #(.WIDTH(RW), .DEPTH(DEPTH)) u_resq (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (strobe_take),
        .push_data ({div_rd, result}),
        .pop       (wb_pop),
        .pop_data  (resq_head),
        .count     (resq_count)
    );

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        if (pipe_wb_en) begin
            rf_we    = 1'b1;
            rf_waddr = pipe_wb_rd;
            rf_wdata = pipe_wb_data;
        end else if ((resq_count != '0) && (res_rd != '0)) begin
            rf_we    = 1'b1;
            rf_waddr = res_rd;
            rf_wdata = res_data;
        end
    end

    // Clear before set so an accept to the same rd in the popping cycle wins.
    always_comb begin
        busy_next = div_busy;
        if (wb_pop) busy_next[res_rd] = 1'b0;
        if (accept && (issue_rd != '0)) busy_next[issue_rd] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_busy <= '0;
            seq_err  <= 1'b0;
        end else begin
            div_busy <= busy_next;
            if (div_out_valid && (!opq_nonempty || (head_rd != div_rd) || (head_op != div_alu_control)))
                seq_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_div_wb_stage.sv
// Directed bench for div_wb_stage: queue-level reference model checked every cycle
// plus literal expectations for the RV64M corner cases and port arbitration.
module tb_div_wb_stage;

    localparam logic [4:0] T_DIV = 5'd12, T_DIVU = 5'd13, T_REM = 5'd14, T_REMU = 5'd15;
    localparam logic [4:0] T_DIVW = 5'd16, T_DIVUW = 5'd17, T_REMW = 5'd18, T_REMUW = 5'd19;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        issue_valid = 1'b0;
    logic        issue_ready;
    logic [63:0] issue_a = '0, issue_b = '0;
    logic [4:0]  issue_rd = '0, issue_alu_control = '0;
    logic        div_out_valid = 1'b0;
    logic [63:0] div_q = '0, div_r = '0;
    logic [4:0]  div_rd = '0, div_alu_control = '0;
    logic        pipe_wb_en = 1'b0;
    logic [4:0]  pipe_wb_rd = '0;
    logic [63:0] pipe_wb_data = '0;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [63:0] rf_wdata;
    logic [31:0] div_busy;
    logic        seq_err;

    int vectors = 0;
    int errs = 0;

    div_wb_stage #(.DEPTH(2), .XLEN(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_a(issue_a), .issue_b(issue_b), .issue_rd(issue_rd),
        .issue_alu_control(issue_alu_control),
        .div_out_valid(div_out_valid), .div_q(div_q), .div_r(div_r),
        .div_rd(div_rd), .div_alu_control(div_alu_control),
        .pipe_wb_en(pipe_wb_en), .pipe_wb_rd(pipe_wb_rd), .pipe_wb_data(pipe_wb_data),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .div_busy(div_busy), .seq_err(seq_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Architectural RV64M result from the operands alone; only unknown ops look at q.
    function automatic logic [63:0] model_result(input logic [63:0] a, input logic [63:0] b,
                                                 input logic [4:0] op, input logic [63:0] q);
        longint      sa, sb;
        int          sa32, sb32;
        logic [31:0] ua, ub, w;
        logic        ovf64, ovf32;
        sa = a; sb = b; ua = a[31:0]; ub = b[31:0]; sa32 = ua; sb32 = ub;
        ovf64 = (a == 64'h8000_0000_0000_0000) && (b == '1);
        ovf32 = (ua == 32'h8000_0000) && (ub == '1);
        w = '0;
        case (op)
            T_DIV:   return (b == 0) ? '1 : (ovf64 ? a : 64'(sa / sb));
            T_DIVU:  return (b == 0) ? '1 : a / b;
            T_REM:   return (b == 0) ? a : (ovf64 ? 64'd0 : 64'(sa % sb));
            T_REMU:  return (b == 0) ? a : a % b;
            T_DIVW:  w = (ub == 0) ? '1 : (ovf32 ? ua : 32'(sa32 / sb32));
            T_DIVUW: w = (ub == 0) ? '1 : ua / ub;
            T_REMW:  w = (ub == 0) ? ua : (ovf32 ? 32'd0 : 32'(sa32 % sb32));
            T_REMUW: w = (ub == 0) ? ua : ua % ub;
            default: return q;
        endcase
        return {{32{w[31]}}, w};
    endfunction

    typedef struct { logic [63:0] a; logic [63:0] b; logic [4:0] rd; logic [4:0] op; } opq_t;
    typedef struct { logic [4:0] rd; logic [63:0] d; } res_t;

    opq_t        opq_m[$];
    res_t        resq_m[$];
    logic [31:0] busy_m = '0;
    logic        serr_m = 1'b0;
    logic [4:0]  wlog[$];

    always @(negedge clk) begin : model_chk
        logic        exp_ready, exp_we, acc;
        logic [4:0]  exp_addr;
        logic [63:0] exp_data;
        opq_t        h;
        if (!rst_n) begin
            opq_m.delete(); resq_m.delete(); busy_m = '0; serr_m = 1'b0;
        end
        exp_ready = (opq_m.size() + resq_m.size()) < 2;
        exp_we = 1'b0; exp_addr = '0; exp_data = '0;
        if (pipe_wb_en) begin
            exp_we = 1'b1; exp_addr = pipe_wb_rd; exp_data = pipe_wb_data;
        end else if (resq_m.size() > 0 && resq_m[0].rd != 0) begin
            exp_we = 1'b1; exp_addr = resq_m[0].rd; exp_data = resq_m[0].d;
        end
        check("issue_ready", issue_ready, exp_ready);
        check("rf_we", rf_we, exp_we);
        check("rf_waddr", rf_waddr, exp_addr);
        check("rf_wdata", rf_wdata, exp_data);
        check("div_busy", div_busy, busy_m);
        check("seq_err", seq_err, serr_m);
        if (rf_we) wlog.push_back(rf_waddr);
        if (rst_n) begin
            acc = issue_valid && exp_ready;
            if (!pipe_wb_en && resq_m.size() > 0) begin
                busy_m[resq_m[0].rd] = 1'b0;
                void'(resq_m.pop_front());
            end
            if (div_out_valid) begin
                if (opq_m.size() == 0) serr_m = 1'b1;
                else begin
                    h = opq_m.pop_front();
                    if (h.rd != div_rd || h.op != div_alu_control) serr_m = 1'b1;
                    resq_m.push_back(res_t'{rd: div_rd, d: model_result(h.a, h.b, div_alu_control, div_q)});
                end
            end
            if (acc) begin
                opq_m.push_back(opq_t'{a: issue_a, b: issue_b, rd: issue_rd, op: issue_alu_control});
                if (issue_rd != 0) busy_m[issue_rd] = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_issue(input logic [63:0] a, input logic [63:0] b,
                            input logic [4:0] rd, input logic [4:0] op);
        int n = 0;
        while (!issue_ready && n < 20) begin tick(); n++; end
        if (!issue_ready) begin
            errs++;
            $display("FAIL issue_wait: issue_ready stayed 0 for %0d cycles, expected 1", n);
        end
        issue_valid = 1'b1; issue_a = a; issue_b = b; issue_rd = rd; issue_alu_control = op;
        tick();
        issue_valid = 1'b0;
    endtask

    task automatic do_strobe(input logic [63:0] q, input logic [63:0] r,
                             input logic [4:0] rd, input logic [4:0] op);
        div_out_valid = 1'b1; div_q = q; div_r = r; div_rd = rd; div_alu_control = op;
        tick();
        div_out_valid = 1'b0;
    endtask

    task automatic run_one(input string name, input logic [63:0] a, input logic [63:0] b,
                           input logic [4:0] rd, input logic [4:0] op,
                           input logic [63:0] q, input logic [63:0] r, input logic [63:0] exp);
        do_issue(a, b, rd, op);
        do_strobe(q, r, rd, op);
        @(negedge clk);
        check({name, "_we"}, rf_we, (rd != 0));
        check({name, "_addr"}, rf_waddr, rd);
        check({name, "_data"}, rf_wdata, exp);
        tick();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int n3;
        #1 rst_n = 1'b0;
        #2;
        check("rst_rf_we", rf_we, 0);
        check("rst_issue_ready", issue_ready, 1);
        check("rst_busy", div_busy, 0);
        check("rst_seq_err", seq_err, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        tick();

        do_issue(64'd100, 64'd7, 5'd5, T_DIV);
        check("busy5_set", div_busy[5], 1);
        do_strobe(64'd14, 64'd2, 5'd5, T_DIV);
        @(negedge clk);
        check("div_we", rf_we, 1);
        check("div_addr", rf_waddr, 5);
        check("div_data", rf_wdata, 64'd14);
        check("busy5_held", div_busy[5], 1);
        tick();
        check("busy5_clear", div_busy[5], 0);

        run_one("rem",   64'd100, 64'd7, 5'd5, T_REM, 64'd14, 64'd2, 64'd2);
        run_one("remu0", 64'd9, 64'd0, 5'd7, T_REMU, 64'h1234, 64'h55, 64'd9);
        run_one("divu0", 64'd9, 64'd0, 5'd7, T_DIVU, 64'h1234, 64'h55, 64'hFFFF_FFFF_FFFF_FFFF);
        run_one("divovf", 64'h8000_0000_0000_0000, '1, 5'd8, T_DIV, 64'h77, 64'h5,
                64'h8000_0000_0000_0000);
        run_one("removf", 64'h8000_0000_0000_0000, '1, 5'd8, T_REM, 64'h77, 64'h5, 64'd0);
        run_one("divwovf", 64'hFFFF_FFFF_8000_0000, '1, 5'd10, T_DIVW, 64'h42, 64'h1,
                64'hFFFF_FFFF_8000_0000);
        run_one("divuw", 64'h8000_0001, 64'd1, 5'd10, T_DIVUW, 64'h0000_0000_8000_0001, 64'd0,
                64'hFFFF_FFFF_8000_0001);
        run_one("remw", 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd11, T_REMW, 64'h0000_0000_FFFF_FFFD,
                64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        run_one("divw0", 64'd5, 64'h1_0000_0000, 5'd11, T_DIVW, 64'h3, 64'h4, '1);
        run_one("remuw0", 64'hABCD_0000_9000_0000, 64'd0, 5'd12, T_REMUW, 64'h3, 64'h4,
                64'hFFFF_FFFF_9000_0000);
        run_one("otherop", 64'd50, 64'd5, 5'd13, 5'd3, 64'h1234, 64'h9, 64'h1234);
        run_one("rd0", 64'd50, 64'd5, 5'd0, T_DIV, 64'd10, 64'd0, 64'd0);

        // Pipe priority: main pipeline owns the port for three cycles.
        wlog.delete();
        do_issue(64'd20, 64'd4, 5'd3, T_DIV);
        do_issue(64'd30, 64'd5, 5'd4, T_DIV);
        check("full_ready", issue_ready, 0);
        pipe_wb_en = 1'b1; pipe_wb_rd = 5'd9; pipe_wb_data = 64'hAA;
        div_out_valid = 1'b1; div_q = 64'd5; div_r = 64'd0; div_rd = 5'd3; div_alu_control = T_DIV;
        tick();
        div_out_valid = 1'b0;
        tick();
        tick();
        pipe_wb_en = 1'b0;
        check("held_ready", issue_ready, 0);
        tick();
        check("pop_ready", issue_ready, 1);
        check("wlog_len", wlog.size(), 4);
        for (int i = 0; i < 4 && i < wlog.size(); i++)
            check($sformatf("wlog_%0d", i), wlog[i], (i < 3) ? 5'd9 : 5'd3);
        n3 = 0;
        foreach (wlog[i]) if (wlog[i] == 5'd3) n3++;
        check("rd3_once", n3, 1);
        do_strobe(64'd6, 64'd0, 5'd4, T_DIV);
        tick();
        tick();

        // Divider echo disagrees with the operand queue head.
        check("serr_pre", seq_err, 0);
        do_issue(64'd20, 64'd4, 5'd3, T_DIV);
        do_strobe(64'd5, 64'd0, 5'd6, T_DIV);
        check("serr_set", seq_err, 1);
        @(negedge clk);
        check("serr_wr_addr", rf_waddr, 6);
        check("serr_wr_data", rf_wdata, 64'd5);
        tick(); tick(); tick();
        check("serr_sticky", seq_err, 1);
        check("stale_busy3", div_busy[3], 1);

        // Asynchronous reset with both queues occupied.
        pipe_wb_en = 1'b1; pipe_wb_rd = 5'd9; pipe_wb_data = 64'hAA;
        do_issue(64'd1, 64'd1, 5'd14, T_DIVU);
        do_strobe(64'd1, 64'd0, 5'd14, T_DIVU);
        do_issue(64'd2, 64'd1, 5'd15, T_DIVU);
        pipe_wb_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_we", rf_we, 0);
        check("arst_addr", rf_waddr, 0);
        check("arst_data", rf_wdata, 0);
        check("arst_busy", div_busy, 0);
        check("arst_ready", issue_ready, 1);
        check("arst_serr", seq_err, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        tick(); tick(); tick();

        // Strobe with nothing outstanding.
        do_strobe(64'd7, 64'd0, 5'd1, T_DIV);
        check("empty_serr", seq_err, 1);
        check("empty_busy", div_busy, 0);
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
